// File: rtl/ahfp_addsub_pipe.sv
// rtl/ahfp_addsub_pipe.sv - pipelined parametrised FP add/sub; AHFP_ADDSUB_RNE_EN selects round-to-nearest-even
module ahfp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic                       start,
    input  logic                       n,
    input  logic [EXP_W+MAN_W:0]       dataa,
    input  logic [EXP_W+MAN_W:0]       datab,
    output logic [EXP_W+MAN_W:0]       result,
    output logic                       done
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int FW = MAN_W + 4;          // hidden + mantissa + guard/round/sticky
    localparam int SW = MAN_W + 5;          // FW plus carry
    localparam int EW = EXP_W + 8;          // headroom so exponent underflow stays signed
    localparam int LW = $clog2(MAN_W + 5);
    localparam int XW = 2 * MAN_W + 7;      // aligned field plus every bit that can be shifted out
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0]    EMAX     = {8'd0, EXP_ONES};

    // stage 0: operand capture
    logic         v0, n0;
    logic [W-1:0] a0, b0;

    // capture the issued operation
    always_ff @(posedge clk) begin
        if (reset) begin
            v0 <= 1'b0;
        end else if (clk_en) begin
            v0 <= start;
            n0 <= n;
            a0 <= dataa;
            b0 <= datab;
        end
    end

    // stage 1: unpack, flush denormals, order so |X| >= |Y|
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W:0]   fa, fb;
    logic             sa, sbe, swap, a_inf, b_inf;

    // unpack both operands and decide the swap
    always_comb begin
        ea    = a0[W-2:MAN_W];
        eb    = b0[W-2:MAN_W];
        sa    = a0[W-1];
        sbe   = b0[W-1] ^ n0;
        fa    = (ea == '0) ? '0 : {1'b1, a0[MAN_W-1:0]};
        fb    = (eb == '0) ? '0 : {1'b1, b0[MAN_W-1:0]};
        a_inf = (ea == EXP_ONES);
        b_inf = (eb == EXP_ONES);
        swap  = (eb > ea) || ((eb == ea) && (fb > fa));
    end

    logic             v1, sg1, sub1, inf1, infs1;
    logic [EXP_W-1:0] ex1, d1;
    logic [MAN_W:0]   mx1, my1;

    // register the ordered operands
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
        end else if (clk_en) begin
            v1    <= v0;
            sg1   <= swap ? sbe : sa;
            sub1  <= sa ^ sbe;
            ex1   <= swap ? eb : ea;
            mx1   <= swap ? fb : fa;
            my1   <= swap ? fa : fb;
            d1    <= swap ? (eb - ea) : (ea - eb);
            inf1  <= a_inf | b_inf;
            infs1 <= a_inf ? sa : sbe;
        end
    end

    // stage 2: align Y and add/subtract magnitudes
    logic [LW-1:0] sh;
    logic [XW-1:0] wide;
    logic [FW-1:0] xf, yf;
    logic [SW-1:0] sum;

    // alignment shift with sticky collection, then magnitude add/sub
    always_comb begin
        if (int'(d1) > MAN_W + 3) sh = LW'(MAN_W + 3);
        else                      sh = LW'(d1);
        wide  = {my1, 3'b000, {(MAN_W + 3){1'b0}}} >> sh;
        yf    = wide[XW-1:MAN_W+3];
        yf[0] = yf[0] | (|wide[MAN_W+2:0]);
        xf    = {mx1, 3'b000};
        sum   = sub1 ? ({1'b0, xf} - {1'b0, yf}) : ({1'b0, xf} + {1'b0, yf});
    end

    logic             v2, sg2, inf2, infs2;
    logic [EXP_W-1:0] ex2;
    logic [SW-1:0]    sum2;

    // register the raw magnitude sum
    always_ff @(posedge clk) begin
        if (reset) begin
            v2 <= 1'b0;
        end else if (clk_en) begin
            v2    <= v1;
            sg2   <= sg1;
            ex2   <= ex1;
            sum2  <= sum;
            inf2  <= inf1;
            infs2 <= infs1;
        end
    end

    // stage 3: normalise
    logic [LW-1:0] lzc;
    logic [FW-1:0] nm;
    logic [EW-1:0] ne;
    logic          nz;

    // carry renormalise right, otherwise leading-zero count and shift left
    always_comb begin
        lzc = LW'(FW);
        for (int i = 0; i < FW; i++) begin
            if (sum2[i]) lzc = LW'(FW - 1 - i);
        end
        nz = (sum2 == '0);
        if (sum2[SW-1]) begin
            nm    = sum2[SW-1:1];
            nm[0] = sum2[1] | sum2[0];
            ne    = {8'd0, ex2} + EW'(1);
        end else begin
            nm = sum2[FW-1:0] << lzc;
            ne = {8'd0, ex2} - EW'(lzc);
        end
    end

    logic          v3, sg3, zero3, inf3, infs3;
    logic [EW-1:0] ne3;
    logic [FW-1:0] nm3;

    // register the normalised value
    always_ff @(posedge clk) begin
        if (reset) begin
            v3 <= 1'b0;
        end else if (clk_en) begin
            v3    <= v2;
            sg3   <= sg2;
            ne3   <= ne;
            nm3   <= nm;
            zero3 <= nz;
            inf3  <= inf2;
            infs3 <= infs2;
        end
    end

    // stage 4: round and pack
    logic [MAN_W-1:0] frac;
    logic [EW-1:0]    fe;
    logic [W-1:0]     res_c;
    logic             unused_bits;
`ifdef AHFP_ADDSUB_RNE_EN
    logic             inc;
    logic [MAN_W+1:0] rsum;
`endif

    // rounding, then zero/underflow/overflow/infinity packing
    always_comb begin
`ifdef AHFP_ADDSUB_RNE_EN
        inc  = nm3[2] & (nm3[1] | nm3[0] | nm3[3]);
        rsum = {1'b0, nm3[FW-1:3]} + {{(MAN_W + 1){1'b0}}, inc};
        if (rsum[MAN_W+1]) begin
            fe   = ne3 + EW'(1);
            frac = '0;
        end else begin
            fe   = ne3;
            frac = rsum[MAN_W-1:0];
        end
        unused_bits = rsum[MAN_W];
`else
        fe          = ne3;
        frac        = nm3[FW-2:3];
        unused_bits = ^{nm3[FW-1], nm3[2:0]};
`endif
        if (inf3)
            res_c = {infs3, EXP_ONES, {MAN_W{1'b0}}};
        else if (zero3 || fe[EW-1] || (fe == '0))
            res_c = '0;
        else if (fe >= EMAX)
            res_c = {sg3, EXP_ONES, {MAN_W{1'b0}}};
        else
            res_c = {sg3, fe[EXP_W-1:0], frac};
    end

    // output register; result only updates on a completing operation
    always_ff @(posedge clk) begin
        if (reset) begin
            done   <= 1'b0;
            result <= '0;
        end else if (clk_en) begin
            done <= v3;
            if (v3) result <= res_c;
        end
    end
endmodule

// File: tb/tb_ahfp_addsub_pipe.sv
// tb/tb_ahfp_addsub_pipe.sv - directed self-checking bench for ahfp_addsub_pipe
module tb_ahfp_addsub_pipe;
    localparam logic [31:0] ONE   = 32'h3F800000;
    localparam logic [31:0] TWO   = 32'h40000000;
    localparam logic [31:0] THREE = 32'h40400000;
    localparam logic [31:0] FOUR  = 32'h40800000;
    localparam logic [31:0] FIVE  = 32'h40A00000;

    logic        clk = 1'b0;
    logic        reset, clk_en, start, n;
    logic [31:0] dataa, datab, result;
    logic        done;
    logic        start_h;
    logic [15:0] dataa_h, datab_h, result_h;
    logic        done_h;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ahfp_addsub_pipe dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
        .dataa(dataa), .datab(datab), .result(result), .done(done)
    );

    ahfp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start_h), .n(n),
        .dataa(dataa_h), .datab(datab_h), .result(result_h), .done(done_h)
    );

    task automatic cyc(input logic st, input logic en, input logic nn,
                       input logic [31:0] a, input logic [31:0] b);
        start  = st;
        clk_en = en;
        n      = nn;
        dataa  = a;
        datab  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, ONE, ONE);
        cyc(1'b1, 1'b1, 1'b0, ONE, ONE);
        reset = 1'b0;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL reset_start_discard cyc %0d got %b want 0", i, done); end
        end
    endtask

    task automatic test_latency();
        logic exp_d;
        drain();
        cyc(1'b1, 1'b1, 1'b1, THREE, ONE);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            exp_d = (i == 4);
            checks++;
            if (done !== exp_d) begin errors++; $display("FAIL latency_done cyc %0d got %b want %b", i, done, exp_d); end
        end
        checks++;
        if (result !== TWO) begin errors++; $display("FAIL latency_result got %h want %h", result, TWO); end
    endtask

    task automatic test_directed();
        logic        vn [12];
        logic [31:0] va [12];
        logic [31:0] vb [12];
        logic [31:0] ve [12];
        vn[0]  = 1; va[0]  = ONE;          vb[0]  = ONE;          ve[0]  = 32'h00000000;
        vn[1]  = 0; va[1]  = ONE;          vb[1]  = 32'hBF800000; ve[1]  = 32'h00000000;
        vn[3]  = 0; va[3]  = 32'h7F7FFFFF; vb[3]  = 32'h7F7FFFFF; ve[3]  = 32'h7F800000;
        vn[4]  = 1; va[4]  = 32'h00800001; vb[4]  = 32'h00800000; ve[4]  = 32'h00000000;
        vn[5]  = 0; va[5]  = ONE;          vb[5]  = 32'h33800000; ve[5]  = 32'h3F800000;
        vn[8]  = 1; va[8]  = ONE;          vb[8]  = THREE;        ve[8]  = 32'hC0000000;
        vn[9]  = 1; va[9]  = ONE;          vb[9]  = 32'h7F800000; ve[9]  = 32'hFF800000;
        vn[10] = 0; va[10] = 32'h00000001; vb[10] = ONE;          ve[10] = ONE;
        vn[11] = 1; va[11] = 32'h7F800000; vb[11] = 32'h7F800000; ve[11] = 32'h7F800000;
        vn[2]  = 0; va[2]  = ONE;          vb[2]  = 32'h33C00000;
        vn[6]  = 0; va[6]  = 32'h3F800001; vb[6]  = 32'h33800000;
        vn[7]  = 0; va[7]  = 32'h3FFFFFFF; vb[7]  = 32'h33C00000;
`ifdef AHFP_ADDSUB_RNE_EN
        ve[2] = 32'h3F800001; ve[6] = 32'h3F800002; ve[7] = 32'h40000000;
`else
        ve[2] = 32'h3F800000; ve[6] = 32'h3F800001; ve[7] = 32'h3FFFFFFF;
`endif
        drain();
        for (int v = 0; v < 12; v++) begin
            cyc(1'b1, 1'b1, vn[v], va[v], vb[v]);
            for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            checks++;
            if (done !== 1'b1) begin errors++; $display("FAIL vec%0d_done got %b want 1", v, done); end
            checks++;
            if (result !== ve[v]) begin errors++; $display("FAIL vec%0d_result got %h want %h", v, result, ve[v]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r_exp [4];
        r_exp[0] = TWO; r_exp[1] = TWO; r_exp[2] = FOUR; r_exp[3] = 32'h0;
        drain();
        cyc(1'b1, 1'b1, 1'b0, ONE, ONE);
        cyc(1'b1, 1'b1, 1'b1, THREE, ONE);
        cyc(1'b1, 1'b1, 1'b0, TWO, TWO);
        cyc(1'b1, 1'b1, 1'b1, FIVE, FIVE);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_early_done got %b want 0", done); end
        for (int j = 0; j < 5; j++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            checks++;
            if (done !== (j < 4)) begin errors++; $display("FAIL b2b_done cyc %0d got %b want %b", j, done, (j < 4)); end
            if (j < 4) begin
                checks++;
                if (result !== r_exp[j]) begin errors++; $display("FAIL b2b_result cyc %0d got %h want %h", j, result, r_exp[j]); end
            end
        end
    endtask

    task automatic test_stall();
        logic        en_p  [7];
        logic        d_p   [7];
        logic [31:0] r_p   [7];
        en_p = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        d_p  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        r_p  = '{TWO, TWO, TWO, TWO, FOUR, 32'h0, 32'h0};
        drain();
        cyc(1'b1, 1'b1, 1'b0, ONE, ONE);
        cyc(1'b1, 1'b1, 1'b1, THREE, ONE);
        cyc(1'b1, 1'b1, 1'b0, TWO, TWO);
        cyc(1'b1, 1'b1, 1'b1, FIVE, FIVE);
        for (int j = 0; j < 7; j++) begin
            // start raised while disabled must not issue anything
            cyc(!en_p[j], en_p[j], 1'b0, THREE, THREE);
            start = 1'b0;
            checks++;
            if (done !== d_p[j]) begin errors++; $display("FAIL stall_done cyc %0d got %b want %b", j, done, d_p[j]); end
            checks++;
            if (result !== r_p[j]) begin errors++; $display("FAIL stall_result cyc %0d got %h want %h", j, result, r_p[j]); end
        end
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL stall_ignored_start cyc %0d got %b want 0", j, done); end
        end
    endtask

    task automatic test_reset_midflight();
        drain();
        cyc(1'b1, 1'b1, 1'b0, THREE, ONE);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, ONE, ONE);
        reset = 1'b0;
        for (int j = 0; j < 6; j++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL midreset_done cyc %0d got %b want 0", j, done); end
        end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL midreset_result got %h want 0", result); end
    endtask

    task automatic test_half();
        drain();
        start_h = 1'b1;
        dataa_h = 16'h3C00;
        datab_h = 16'h3C00;
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        start_h = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        checks++;
        if (done_h !== 1'b1) begin errors++; $display("FAIL half_done got %b want 1", done_h); end
        checks++;
        if (result_h !== 16'h4000) begin errors++; $display("FAIL half_result got %h want 4000", result_h); end
    endtask

    initial begin
        reset   = 1'b1;
        clk_en  = 1'b1;
        start   = 1'b0;
        n       = 1'b0;
        dataa   = '0;
        datab   = '0;
        start_h = 1'b0;
        dataa_h = '0;
        datab_h = '0;
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_half();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
